cic_ch_sched: RTL

//  Time-multiplexes one cic decimator across N_CH sigma-delta sensor channels.

---
 rtl/cic_ch_sched_pkg.sv | 26 ++
 rtl/cic_ch_sched_if.sv | 13 +
 rtl/cic_ch_sched_rr_pick.sv | 39 +++
 rtl/cic_ch_sched.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cic_ch_sched_pkg.sv
// Shared state encoding and elaboration-time helpers for the CIC channel scheduler.
// Used for port widths and counter sizing in the scheduler and its channel picker.
package cic_ch_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SELECT  = 3'd1,
      ST_FLUSH   = 3'd2,
      ST_SETTLE  = 3'd3,
      ST_CAPTURE = 3'd4
   } state_t;

   function automatic int f_clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

   function automatic int f_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/cic_ch_sched_if.sv
// Forwarded-sample stream: one decimated word tagged with its channel, valid/ready handshake.
interface cic_ch_sched_if #(
   parameter int O_WIDTH = 8,
   parameter int CW      = 2
);
   logic [O_WIDTH-1:0] data;
   logic [CW-1:0]      ch;
   logic               valid;
   logic               ready;

   modport master (output data, output ch, output valid, input ready);
   modport slave  (input data, input ch, input valid, output ready);
endinterface

// File: rtl/cic_ch_sched_rr_pick.sv
// Combinational round-robin picker: first enabled channel strictly after i_ch,
// or from channel 0 inclusive when i_first is set.
module cic_ch_sched_rr_pick #(
   parameter int N_CH = 4,
   parameter int CW   = 2
) (
   input  logic [N_CH-1:0] i_mask,
   input  logic [CW-1:0]   i_ch,
   input  logic            i_first,
   output logic [CW-1:0]   o_ch,
   output logic            o_found
);
   logic [CW-1:0]   w_cand [N_CH];
   logic [N_CH-1:0] w_hit;

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_cand
         // One extra bit holds i_ch + offset before the wrap back into 0..N_CH-1.
         logic [CW:0] w_sum;
         assign w_sum = i_first ? (CW+1)'(gi) : ({1'b0, i_ch} + (CW+1)'(gi + 1));
         assign w_cand[gi] = (w_sum >= (CW+1)'(N_CH)) ? CW'(w_sum - (CW+1)'(N_CH))
                                                      : w_sum[CW-1:0];
         assign w_hit[gi]  = i_mask[w_cand[gi]];
      end
   endgenerate

   always_comb begin
      o_found = 1'b0;
      o_ch    = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (w_hit[k]) begin
            o_found = 1'b1;
            o_ch    = w_cand[k];
         end
      end
   end

endmodule

// File: rtl/cic_ch_sched.sv
// Time-multiplexes one CIC decimator over N_CH sigma-delta channels: flush, settle,
// then forward SAMPLES tagged words per visit through a single-entry output register.
module cic_ch_sched
   import cic_ch_sched_pkg::*;
#(
   parameter int N_CH      = 4,
   parameter int I_WIDTH   = 2,
   parameter int O_WIDTH   = 8,
   parameter int SETTLE    = 1,
   parameter int SAMPLES   = 4,
   parameter int FLUSH_CYC = 2
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_start,
   input  logic                    i_stop,
   input  logic [N_CH-1:0]         i_ch_mask,
   input  logic [N_CH*I_WIDTH-1:0] i_sd,
   output logic                    o_cic_en,
   output logic                    o_cic_rst,
   output logic [I_WIDTH-1:0]      o_cic_data,
   input  logic [O_WIDTH-1:0]      i_cic_data,
   input  logic                    i_cic_clk,
   cic_ch_sched_if.master          o_stream,
   output logic                    o_busy,
   output logic                    o_overrun
);
   localparam int CW      = f_max(1, f_clog2(N_CH));
   localparam int CNT_MAX = f_max(f_max(SETTLE, SAMPLES), FLUSH_CYC);
   localparam int CNTW    = f_max(1, f_clog2(CNT_MAX + 1));

   localparam logic [CNTW-1:0] FLUSH_LAST  = CNTW'(FLUSH_CYC - 1);
   localparam logic [CNTW-1:0] SETTLE_LAST = CNTW'(f_max(SETTLE, 1) - 1);
   localparam logic [CNTW-1:0] SAMPLE_LAST = CNTW'(SAMPLES - 1);

   state_t              r_state;
   state_t              w_state_next;
   logic [CW-1:0]       r_ch;
   logic [CW-1:0]       w_ch_next;
   logic [CNTW-1:0]     r_cnt;
   logic [CNTW-1:0]     w_cnt_next;
   logic                r_cclk_q;
   logic                r_stop_pend;
   logic                r_first;
   logic [O_WIDTH-1:0]  r_data;
   logic [CW-1:0]       r_och;
   logic                r_valid;
   logic                r_overrun;

   logic                w_strb;
   logic                w_offer;
   logic                w_load_ok;
   logic                w_accept;
   logic [CW-1:0]       w_pick_ch;
   logic                w_pick_found;
   logic [I_WIDTH-1:0]  w_sd_ch [N_CH];

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_sd
         assign w_sd_ch[gi] = i_sd[gi*I_WIDTH +: I_WIDTH];
      end
   endgenerate

   cic_ch_sched_rr_pick #(.N_CH(N_CH), .CW(CW)) u_pick (
      .i_mask  (i_ch_mask),
      .i_ch    (r_ch),
      .i_first (r_first),
      .o_ch    (w_pick_ch),
      .o_found (w_pick_found)
   );

   // The decimated clock is sampled as data; its rising edge marks fresh i_cic_data.
   assign w_strb     = i_cic_clk & ~r_cclk_q;
   assign w_load_ok  = ~r_valid | o_stream.ready;
   assign w_accept   = r_valid & o_stream.ready;

   always_comb begin
      w_state_next = r_state;
      w_ch_next    = r_ch;
      w_cnt_next   = r_cnt;
      w_offer      = 1'b0;
      o_cic_rst    = 1'b0;
      o_cic_en     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            o_cic_rst = 1'b1;
            if (i_start && (|i_ch_mask)) w_state_next = ST_SELECT;
         end
         ST_SELECT: begin
            if (w_pick_found) begin
               w_ch_next    = w_pick_ch;
               w_cnt_next   = '0;
               w_state_next = ST_FLUSH;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            o_cic_rst = 1'b1;
            if (r_cnt == FLUSH_LAST) begin
               w_cnt_next   = '0;
               w_state_next = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         ST_SETTLE: begin
            o_cic_en = 1'b1;
            if (w_strb) begin
               if (r_cnt == SETTLE_LAST) begin
                  w_cnt_next   = '0;
                  w_state_next = ST_CAPTURE;
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
         end
         ST_CAPTURE: begin
            o_cic_en = 1'b1;
            if (w_strb) begin
               w_offer = 1'b1;
               if (r_cnt == SAMPLE_LAST) begin
                  w_cnt_next   = '0;
                  w_state_next = r_stop_pend ? ST_IDLE : ST_SELECT;
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_ch        <= '0;
         r_cnt       <= '0;
         r_cclk_q    <= 1'b0;
         r_stop_pend <= 1'b0;
         r_first     <= 1'b1;
      end else begin
         r_state  <= w_state_next;
         r_ch     <= w_ch_next;
         r_cnt    <= w_cnt_next;
         r_cclk_q <= i_cic_clk;
         // Covers start+stop in the same IDLE cycle: the visit begins with stop pending.
         if (w_state_next == ST_IDLE) r_stop_pend <= 1'b0;
         else if (i_stop)             r_stop_pend <= 1'b1;
         if (r_state == ST_IDLE)        r_first <= 1'b1;
         else if (r_state == ST_SELECT) r_first <= 1'b0;
      end
   end

   // Dropped words still count toward SAMPLES; the held word survives channel switches.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_data    <= '0;
         r_och     <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (w_offer && w_load_ok) begin
            r_data  <= i_cic_data;
            r_och   <= r_ch;
            r_valid <= 1'b1;
         end else if (w_accept) begin
            r_valid <= 1'b0;
         end
         if (w_offer && !w_load_ok) r_overrun <= 1'b1;
         else if (i_start)          r_overrun <= 1'b0;
      end
   end

   assign o_stream.data  = r_data;
   assign o_stream.ch    = r_och;
   assign o_stream.valid = r_valid;
   assign o_cic_data     = (r_state == ST_IDLE) ? '0 : w_sd_ch[r_ch];
   assign o_busy         = (r_state != ST_IDLE);
   assign o_overrun      = r_overrun;

endmodule
